// File: rtl/mouse_paddle_pkg.sv
// Shared types and constants for the mouse-to-paddle adapter.
package mouse_paddle_pkg;

  typedef enum logic {
    MODE_JOY   = 1'b0,
    MODE_MOUSE = 1'b1
  } mode_e;

  // hps_io ps2_mouse bus layout
  localparam int STB   = 24;
  localparam int DY_HI = 23;
  localparam int DX_HI = 15;
  localparam int YS    = 5;
  localparam int XS    = 4;

  // Signed 8-bit axis range seen by the core
  localparam int AXIS_MAX = 127;
  localparam int AXIS_MIN = -128;

  // Number of registered pipeline stages between strobe sample and accumulate
  localparam int STAGES = 2;

endpackage

// File: rtl/sat_axis_accum.sv
// One axis of the mouse pipeline: per-packet clamp (P2) followed by a
// saturating accumulate into a 9-bit signed position (P3).
module sat_axis_accum
  import mouse_paddle_pkg::*;
#(
  parameter int CLAMP = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              p1_vld_i,
  input  logic              p2_vld_i,
  input  logic signed [8:0] delta_i,
  output logic signed [8:0] acc_o
);

  localparam logic signed [8:0] CLAMP_P = 9'(CLAMP);
  localparam logic signed [8:0] CLAMP_N = -CLAMP_P;
  localparam logic signed [9:0] SUM_MAX = 10'(AXIS_MAX);
  localparam logic signed [9:0] SUM_MIN = 10'(AXIS_MIN);

  logic signed [8:0] clamp_d;
  logic signed [7:0] clamp_q;
  logic signed [8:0] acc_q;
  logic signed [8:0] acc_d;
  logic signed [9:0] sum;

  // Limit the scaled delta to +/-CLAMP; CLAMP <= 127 so 8 bits hold it
  always_comb begin
    clamp_d = delta_i;
    if (delta_i > CLAMP_P)      clamp_d = CLAMP_P;
    else if (delta_i < CLAMP_N) clamp_d = CLAMP_N;
  end

  // P2 register: holds the clamped delta for the accumulate stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         clamp_q <= '0;
    else if (p1_vld_i) clamp_q <= clamp_d[7:0];
  end

  // Ten bits are enough to hold acc + delta without wrap before saturating
  always_comb begin
    sum   = 10'(acc_q) + 10'(clamp_q);
    acc_d = sum[8:0];
    if (sum > SUM_MAX)      acc_d = 9'(SUM_MAX);
    else if (sum < SUM_MIN) acc_d = 9'(SUM_MIN);
  end

  // P3: flush wins over an accumulate landing in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         acc_q <= '0;
    else if (flush_i)  acc_q <= '0;
    else if (p2_vld_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mouse_paddle_adapter.sv
// Turns hps_io PS/2 mouse packets into absolute signed X/Y paddle axes and
// two fire buttons for joystick port 1. Any analog stick activity or a CPU
// halt hands the port straight back to the physical joystick.
module mouse_paddle_adapter
  import mouse_paddle_pkg::*;
#(
  parameter int SHIFT       = 1,
  parameter int CLAMP       = 10,
  parameter int IDLE_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [24:0] PS2_MOUSE,
  input  logic [15:0] JOYA,
  input  logic [1:0]  JOY_BTN,
  input  logic        CPU_HALT,
  output logic [7:0]  AX,
  output logic [7:0]  AY,
  output logic [1:0]  BTN,
  output logic        MOUSE_ACTIVE
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1) + 1;

  logic              stb_q;
  logic              armed_q;
  logic              pkt_det;
  logic              flush;
  logic [STAGES:1]   vld_q;
  logic signed [8:0] dx9, dy9;
  logic signed [8:0] dx_q, dy_q;
  logic [1:0]        btn1_q, btn2_q, btn_acc_q;
  logic signed [8:0] acc_x, acc_y;
  mode_e             mode_q;
  logic [IDLE_W-1:0] idle_q;
  logic              unused_bits;

  assign unused_bits = ^{PS2_MOUSE[7:6], PS2_MOUSE[3:2]};

  assign flush   = (JOYA != 16'd0) || CPU_HALT;
  assign pkt_det = armed_q && (PS2_MOUSE[STB] != stb_q);
  assign dx9     = {PS2_MOUSE[XS], PS2_MOUSE[DX_HI -: 8]};
  assign dy9     = {PS2_MOUSE[YS], PS2_MOUSE[DY_HI -: 8]};

  // Strobe copy; the first post-reset cycle only loads it so a strobe level
  // held across reset is not mistaken for a new packet
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stb_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      stb_q   <= PS2_MOUSE[STB];
      armed_q <= 1'b1;
    end
  end

  // Valid shift register; flush drops every packet still in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      vld_q <= '0;
    else if (flush) vld_q <= '0;
    else            vld_q <= {vld_q[STAGES-1:1], pkt_det};
  end

  // P1 capture: sign-extended deltas, arithmetic shift rounds toward -inf
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dx_q   <= '0;
      dy_q   <= '0;
      btn1_q <= '0;
      btn2_q <= '0;
    end else begin
      if (pkt_det) begin
        dx_q   <= dx9 >>> SHIFT;
        dy_q   <= dy9 >>> SHIFT;
        btn1_q <= PS2_MOUSE[1:0];
      end
      if (vld_q[1]) btn2_q <= btn1_q;
    end
  end

  sat_axis_accum #(.CLAMP(CLAMP)) u_acc_x (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .flush_i  (flush),
    .p1_vld_i (vld_q[1]),
    .p2_vld_i (vld_q[2]),
    .delta_i  (dx_q),
    .acc_o    (acc_x)
  );

  sat_axis_accum #(.CLAMP(CLAMP)) u_acc_y (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .flush_i  (flush),
    .p1_vld_i (vld_q[1]),
    .p2_vld_i (vld_q[2]),
    .delta_i  (dy_q),
    .acc_o    (acc_y)
  );

  // Mode FSM with idle timeout; accumulators survive a timeout so motion
  // resumes from the last position
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode_q    <= MODE_JOY;
      idle_q    <= '0;
      btn_acc_q <= '0;
    end else if (flush) begin
      mode_q <= MODE_JOY;
      idle_q <= '0;
    end else if (vld_q[2]) begin
      mode_q    <= MODE_MOUSE;
      idle_q    <= '0;
      btn_acc_q <= btn2_q;
    end else if (IDLE_CYCLES > 0 && mode_q == MODE_MOUSE) begin
      if (idle_q == IDLE_W'(IDLE_CYCLES)) begin
        mode_q <= MODE_JOY;
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  // Registered output mux between accumulated mouse position and joystick
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AX           <= '0;
      AY           <= '0;
      BTN          <= '0;
      MOUSE_ACTIVE <= 1'b0;
    end else begin
      MOUSE_ACTIVE <= (mode_q == MODE_MOUSE);
      if (mode_q == MODE_MOUSE) begin
        AX  <= acc_x[7:0];
        AY  <= acc_y[7:0];
        BTN <= btn_acc_q;
      end else begin
        AX  <= JOYA[7:0];
        AY  <= JOYA[15:8];
        BTN <= JOY_BTN;
      end
    end
  end

endmodule

// File: tb/tb_mouse_paddle_adapter.sv
// Bench for mouse_paddle_adapter: pass-through vector table, directed corner
// sequences and randomized traffic against a packet-queue reference model.
module tb_mouse_paddle_adapter;

  localparam int SHIFT = 1;
  localparam int CLAMP = 10;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stb = 1'b0;
  logic [7:0]  pdx = '0, pdy = '0;
  logic        psx = 1'b0, psy = 1'b0;
  logic [1:0]  pbtn = '0;
  logic [15:0] joya = '0;
  logic [1:0]  jbtn = '0;
  logic        halt = 1'b0;
  logic [24:0] ps2;
  logic [7:0]  ax, ay, ax2, ay2;
  logic [1:0]  btn, btn2;
  logic        act, act2;

  assign ps2 = {stb, pdy, pdx, 2'b00, psy, psx, 2'b00, pbtn};

  always #5 CLK = ~CLK;

  mouse_paddle_adapter #(.SHIFT(SHIFT), .CLAMP(CLAMP), .IDLE_CYCLES(0)) dut (
    .CLK(CLK), .RESET(RESET), .PS2_MOUSE(ps2), .JOYA(joya), .JOY_BTN(jbtn),
    .CPU_HALT(halt), .AX(ax), .AY(ay), .BTN(btn), .MOUSE_ACTIVE(act));

  mouse_paddle_adapter #(.SHIFT(SHIFT), .CLAMP(CLAMP), .IDLE_CYCLES(100)) dut_idle (
    .CLK(CLK), .RESET(RESET), .PS2_MOUSE(ps2), .JOYA(joya), .JOY_BTN(jbtn),
    .CPU_HALT(halt), .AX(ax2), .AY(ay2), .BTN(btn2), .MOUSE_ACTIVE(act2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         k;
    int         dx;
    int         dy;
    logic [1:0] b;
  } pend_t;

  pend_t      pq[$];
  int         ecount;
  int         m_acc_x, m_acc_y;
  bit         m_mode;
  logic [1:0] m_btn;
  bit         m_armed;
  logic       m_stb;
  logic [7:0] e_ax, e_ay;
  logic [1:0] e_btn;
  logic       e_act;

  function automatic int s9(input logic s, input logic [7:0] d);
    return s ? int'(d) - 256 : int'(d);
  endfunction

  // floor(v / 2^SHIFT), then limit to +/-CLAMP
  function automatic int scl(input int v);
    int q;
    int div = 1 << SHIFT;
    q = (v >= 0) ? v / div : -((-v + div - 1) / div);
    if (q > CLAMP)  q = CLAMP;
    if (q < -CLAMP) q = -CLAMP;
    return q;
  endfunction

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    pq.delete();
    ecount = 0; m_acc_x = 0; m_acc_y = 0; m_mode = 0; m_btn = '0;
    m_armed = 0; m_stb = 1'b0;
    e_ax = '0; e_ay = '0; e_btn = '0; e_act = 1'b0;
  endtask

  // One clock edge of the reference: outputs reflect the state before the edge,
  // an accepted packet lands on the accumulators two edges after it is seen.
  task automatic model_edge();
    bit    fl;
    bit    det;
    pend_t p;
    fl    = (joya != 16'd0) || halt;
    e_ax  = m_mode ? 8'(m_acc_x) : joya[7:0];
    e_ay  = m_mode ? 8'(m_acc_y) : joya[15:8];
    e_btn = m_mode ? m_btn : jbtn;
    e_act = m_mode;
    det   = m_armed && (stb != m_stb);
    m_stb = stb;
    m_armed = 1;
    if (fl) begin
      m_acc_x = 0; m_acc_y = 0; m_mode = 0;
      pq.delete();
    end else begin
      if (pq.size() > 0 && pq[0].k == ecount) begin
        p = pq.pop_front();
        m_acc_x = sat(m_acc_x + p.dx);
        m_acc_y = sat(m_acc_y + p.dy);
        m_mode  = 1;
        m_btn   = p.b;
      end
      if (det) pq.push_back('{ecount + 2, scl(s9(psx, pdx)), scl(s9(psy, pdy)), pbtn});
    end
    ecount++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    chk("ax", ax, e_ax);
    chk("ay", ay, e_ay);
    chk("btn", btn, e_btn);
    chk("act", act, e_act);
  endtask

  task automatic send(input logic [8:0] x, input logic [8:0] y, input logic [1:0] b);
    psx = x[8]; pdx = x[7:0];
    psy = y[8]; pdy = y[7:0];
    pbtn = b;
    stb = ~stb;
    tick();
  endtask

  task automatic do_reset(input logic stb_init);
    RESET = 1'b1;
    stb = stb_init; joya = '0; jbtn = '0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ax", ax, 8'h00);
    chk("rst_ay", ay, 8'h00);
    chk("rst_btn", btn, 2'b00);
    chk("rst_act", act, 1'b0);
    RESET = 1'b0;
  endtask

  // ---------------- pass-through table ----------------
  typedef struct {
    logic [15:0] joya;
    logic [1:0]  jbtn;
    logic        halt;
    logic [7:0]  ax;
    logic [7:0]  ay;
    logic [1:0]  btn;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{16'h40C0, 2'b10, 1'b0, 8'hC0, 8'h40, 2'b10};
    vt[1] = '{16'h7F80, 2'b01, 1'b0, 8'h80, 8'h7F, 2'b01};
    vt[2] = '{16'h0000, 2'b11, 1'b1, 8'h00, 8'h00, 2'b11};
    vt[3] = '{16'h0001, 2'b00, 1'b0, 8'h01, 8'h00, 2'b00};
    vt[4] = '{16'hFF00, 2'b11, 1'b1, 8'h00, 8'hFF, 2'b11};

    do_reset(1'b0);

    for (int i = 0; i < 5; i++) begin
      joya = vt[i].joya; jbtn = vt[i].jbtn; halt = vt[i].halt;
      tick();
      chk("tbl_ax", ax, vt[i].ax);
      chk("tbl_ay", ay, vt[i].ay);
      chk("tbl_btn", btn, vt[i].btn);
      chk("tbl_act", act, 1'b0);
    end

    // first mouse packet: clamp on X, negative odd-free shift on Y
    joya = '0; jbtn = '0; halt = 1'b0;
    send(9'h028, 9'h1F4, 2'b01);
    repeat (3) tick();
    chk("pkt1_ax", ax, 8'h0A);
    chk("pkt1_ay", ay, 8'hFA);
    chk("pkt1_btn", btn, 2'b01);
    chk("pkt1_act", act, 1'b1);

    // positive saturation, then step back down
    repeat (15) send(9'h028, 9'h000, 2'b01);
    repeat (3) tick();
    chk("sat_hi_ax", ax, 8'h7F);
    send(9'h1FC, 9'h000, 2'b00);
    repeat (3) tick();
    chk("sat_back_ax", ax, 8'h7D);

    // negative saturation and the -1 rounding case
    repeat (30) send(9'h1D8, 9'h1D8, 2'b10);
    repeat (3) tick();
    chk("sat_lo_ax", ax, 8'h80);
    chk("sat_lo_ay", ay, 8'h80);
    send(9'h1FF, 9'h001, 2'b10);
    repeat (3) tick();
    chk("rnd_ax", ax, 8'h80);
    chk("rnd_ay", ay, 8'h80);

    // back-to-back packets from zero
    halt = 1'b1; tick(); halt = 1'b0;
    send(9'h004, 9'h000, 2'b00);
    send(9'h004, 9'h000, 2'b00);
    send(9'h004, 9'h000, 2'b00);
    repeat (3) tick();
    chk("b2b_ax", ax, 8'h06);

    // halt while a packet sits in P2: it must never land
    halt = 1'b1; tick(); halt = 1'b0;
    send(9'h028, 9'h000, 2'b00);
    tick();
    halt = 1'b1; tick(); halt = 1'b0;
    repeat (2) tick();
    chk("halt_ax", ax, 8'h00);
    chk("halt_act", act, 1'b0);
    send(9'h004, 9'h000, 2'b00);
    repeat (3) tick();
    chk("halt_after_ax", ax, 8'h02);

    // idle timeout on the second instance, accumulators retained
    halt = 1'b1; tick(); halt = 1'b0;
    send(9'h028, 9'h000, 2'b00);
    repeat (3) tick();
    chk("idle_act_on", act2, 1'b1);
    chk("idle_ax_on", ax2, 8'h0A);
    repeat (90) tick();
    chk("idle_act_mid", act2, 1'b1);
    repeat (20) tick();
    chk("idle_act_off", act2, 1'b0);
    chk("idle_ax_off", ax2, 8'h00);
    send(9'h004, 9'h000, 2'b00);
    repeat (3) tick();
    chk("idle_resume_ax", ax2, 8'h0C);
    chk("idle_resume_act", act2, 1'b1);

    // randomized traffic with occasional flushes
    repeat (400) begin
      halt = ($urandom_range(0, 15) == 0);
      joya = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      jbtn = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
      else
        tick();
    end
    halt = 1'b0; joya = '0;
    repeat (4) tick();

    // strobe held high across reset must not count as a packet
    do_reset(1'b1);
    repeat (6) tick();
    chk("armed_act", act, 1'b0);
    chk("armed_ax", ax, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
